// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared FSM state encoding and exception cause codes.
package pipeline_hazard_controller_pkg;
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_e;
   typedef enum logic [1:0] {
      EXC_NONE     = 2'b00,
      EXC_INV_OP   = 2'b01,
      EXC_INV_ADDR = 2'b10
   } cause_e;
   localparam logic [1:0] DRAIN_CYCLES = 2'd2;
endpackage

// File: rtl/pipeline_hazard_controller_hazard_counter.sv
// hazard_counter: saturating up-counter with enable; holds at all-ones instead of wrapping.
module hazard_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d = (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stalls, taken-branch flushes and drain-then-halt on faults
// for a 5-stage pipeline; also keeps exception state and performance counters.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int XLEN       = 64,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_uses_rs1_i,
   input  logic                  id_uses_rs2_i,
   input  logic                  id_inv_op_i,
   input  logic [XLEN-1:0]       id_pc_i,
   input  logic                  id_ex_memread_i,
   input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
   input  logic                  mem_branch_i,
   input  logic                  mem_zero_i,
   input  logic                  mem_inv_addr_i,
   input  logic [XLEN-1:0]       mem_pc_i,
   output logic                  pc_write_o,
   output logic                  pc_src_o,
   output logic                  if_id_write_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_bubble_o,
   output logic                  ex_mem_flush_o,
   output logic                  mem_kill_o,
   output logic                  halted_o,
   output logic [1:0]            exc_cause_o,
   output logic [XLEN-1:0]       epc_o,
   output logic [CNT_W-1:0]      cycle_cnt_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);
   state_e          state_q, state_d;
   cause_e          cause_q, cause_d;
   logic [1:0]      drain_q, drain_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic            load_use, taken, stall_en, flush_en;

   assign taken    = mem_branch_i && mem_zero_i;
   assign load_use = id_ex_memread_i && id_ex_rd_i != '0 &&
                     ((id_uses_rs1_i && id_rs1_i == id_ex_rd_i) ||
                      (id_uses_rs2_i && id_rs2_i == id_ex_rd_i));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cause_q <= EXC_NONE;
         drain_q <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         drain_q <= drain_d;
         epc_q   <= epc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      drain_d = drain_q;
      epc_d   = epc_q;
      case (state_q)
         ST_RUN: begin
            if (mem_inv_addr_i) begin
               state_d = ST_HALT;
               cause_d = EXC_INV_ADDR;
               epc_d   = mem_pc_i;
            end else if (!taken && id_inv_op_i) begin
               state_d = ST_DRAIN;
               cause_d = EXC_INV_OP;
               epc_d   = id_pc_i;
               drain_d = DRAIN_CYCLES;
            end
         end
         ST_DRAIN: begin
            if (mem_inv_addr_i) begin
               state_d = ST_HALT;
               cause_d = EXC_INV_ADDR;
               epc_d   = mem_pc_i;
            end else begin
               drain_d = drain_q - 2'd1;
               state_d = (drain_q == 2'd1) ? ST_HALT : ST_DRAIN;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   // Defaults are the fully frozen/flushed controls used in reset and HALT.
   always_comb begin
      pc_write_o     = 1'b0;
      pc_src_o       = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      ex_mem_flush_o = 1'b1;
      mem_kill_o     = 1'b0;
      stall_en       = 1'b0;
      flush_en       = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_RUN: begin
               if (mem_inv_addr_i) begin
                  mem_kill_o = 1'b1;
               end else if (taken) begin
                  pc_src_o      = 1'b1;
                  pc_write_o    = 1'b1;
                  if_id_write_o = 1'b1;
                  flush_en      = 1'b1;
               end else if (id_inv_op_i) begin
                  if_id_write_o  = 1'b1;
                  ex_mem_flush_o = 1'b0;
               end else if (load_use) begin
                  if_id_flush_o  = 1'b0;
                  ex_mem_flush_o = 1'b0;
                  stall_en       = 1'b1;
               end else begin
                  pc_write_o     = 1'b1;
                  if_id_write_o  = 1'b1;
                  if_id_flush_o  = 1'b0;
                  id_ex_bubble_o = 1'b0;
                  ex_mem_flush_o = 1'b0;
               end
            end
            ST_DRAIN: begin
               if (mem_inv_addr_i) begin
                  mem_kill_o = 1'b1;
               end else begin
                  if_id_write_o  = 1'b1;
                  ex_mem_flush_o = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign halted_o    = (state_q == ST_HALT);
   assign exc_cause_o = cause_q;
   assign epc_o       = epc_q;

   hazard_counter #(.CNT_W(CNT_W)) u_cycle_cnt (.clk(clk), .rst_n(rst_n), .en_i(1'b1),    .cnt_o(cycle_cnt_o));
   hazard_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .en_i(stall_en), .cnt_o(stall_cnt_o));
   hazard_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .en_i(flush_en), .cnt_o(flush_cnt_o));
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scenario tasks with hand-computed expectations (CNT_W=4).
module tb_pipeline_hazard_controller;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1, id_rs2, id_ex_rd;
   logic        id_uses_rs1, id_uses_rs2, id_inv_op, id_ex_memread;
   logic        mem_branch, mem_zero, mem_inv_addr;
   logic [63:0] id_pc, mem_pc, epc;
   logic        pc_write, pc_src, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, mem_kill, halted;
   logic [1:0]  exc_cause;
   logic [3:0]  cycle_cnt, stall_cnt, flush_cnt;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.REG_ADDR_W(5), .XLEN(64), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .id_inv_op_i(id_inv_op), .id_pc_i(id_pc), .id_ex_memread_i(id_ex_memread), .id_ex_rd_i(id_ex_rd),
      .mem_branch_i(mem_branch), .mem_zero_i(mem_zero), .mem_inv_addr_i(mem_inv_addr), .mem_pc_i(mem_pc),
      .pc_write_o(pc_write), .pc_src_o(pc_src), .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
      .id_ex_bubble_o(id_ex_bubble), .ex_mem_flush_o(ex_mem_flush), .mem_kill_o(mem_kill),
      .halted_o(halted), .exc_cause_o(exc_cause), .epc_o(epc),
      .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; id_ex_rd = '0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; id_inv_op = 0; id_ex_memread = 0;
      mem_branch = 0; mem_zero = 0; mem_inv_addr = 0;
      id_pc = '0; mem_pc = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      #1;
      n_chk++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rst_pc_write got %b exp 0", pc_write); end
      n_chk++; if (if_id_write !== 1'b0) begin n_fail++; $display("FAIL rst_if_id_write got %b exp 0", if_id_write); end
      n_chk++; if ({if_id_flush, id_ex_bubble, ex_mem_flush} !== 3'b111) begin n_fail++; $display("FAIL rst_flushes got %b exp 111", {if_id_flush, id_ex_bubble, ex_mem_flush}); end
      n_chk++; if (mem_kill !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rst_kill_halt got %b%b exp 00", mem_kill, halted); end
      n_chk++; if ({cycle_cnt, stall_cnt, flush_cnt} !== 12'h000) begin n_fail++; $display("FAIL rst_counters got %h exp 000", {cycle_cnt, stall_cnt, flush_cnt}); end
      n_chk++; if (exc_cause !== 2'b00 || epc !== 64'h0) begin n_fail++; $display("FAIL rst_exc got %b %h exp 00 0", exc_cause, epc); end
      @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      n_chk++; if (cycle_cnt !== 4'd3) begin n_fail++; $display("FAIL cycle_count got %0d exp 3", cycle_cnt); end
      n_chk++; if (pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL run_idle got %b%b%b exp 110", pc_write, if_id_write, id_ex_bubble); end
   endtask

   task automatic test_load_x0();
      id_ex_memread = 1; id_ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1;
      #1;
      n_chk++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL x0_no_stall got pcw=%b bub=%b exp 1 0", pc_write, id_ex_bubble); end
      @(negedge clk);
      idle();
      n_chk++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL x0_stall_cnt got %0d exp 0", stall_cnt); end
   endtask

   task automatic test_load_use();
      id_ex_memread = 1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1; id_rs2 = 5'd7; id_uses_rs2 = 1;
      #1;
      n_chk++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b001) begin n_fail++; $display("FAIL load_use_ctl got %b exp 001", {pc_write, if_id_write, id_ex_bubble}); end
      n_chk++; if (if_id_flush !== 1'b0 || ex_mem_flush !== 1'b0) begin n_fail++; $display("FAIL load_use_noflush got %b%b exp 00", if_id_flush, ex_mem_flush); end
      @(negedge clk);
      idle();
      id_rs1 = 5'd5; id_uses_rs1 = 1;
      #1;
      n_chk++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL load_use_clear got pcw=%b bub=%b exp 1 0", pc_write, id_ex_bubble); end
      n_chk++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL stall_cnt got %0d exp 1", stall_cnt); end
      id_ex_memread = 1; id_ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 0;
      #1;
      n_chk++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL unused_rs2 got pcw=%b exp 1", pc_write); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_branch_priority();
      mem_branch = 1; mem_zero = 0;
      #1;
      n_chk++; if (pc_src !== 1'b0 || pc_write !== 1'b1) begin n_fail++; $display("FAIL not_taken got src=%b pcw=%b exp 0 1", pc_src, pc_write); end
      mem_zero = 1; id_ex_memread = 1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
      #1;
      n_chk++; if ({pc_src, pc_write} !== 2'b11) begin n_fail++; $display("FAIL taken_pc got %b exp 11", {pc_src, pc_write}); end
      n_chk++; if ({if_id_flush, id_ex_bubble, ex_mem_flush} !== 3'b111) begin n_fail++; $display("FAIL taken_flushes got %b exp 111", {if_id_flush, id_ex_bubble, ex_mem_flush}); end
      @(negedge clk);
      idle();
      n_chk++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd1) begin n_fail++; $display("FAIL taken_counts got flush=%0d stall=%0d exp 1 1", flush_cnt, stall_cnt); end
   endtask

   task automatic test_inv_op();
      id_inv_op = 1; id_pc = 64'h10;
      #1;
      n_chk++; if ({pc_write, if_id_flush, id_ex_bubble} !== 3'b011) begin n_fail++; $display("FAIL inv_op_ctl got %b exp 011", {pc_write, if_id_flush, id_ex_bubble}); end
      @(negedge clk);
      idle();
      mem_branch = 1; mem_zero = 1;
      #1;
      n_chk++; if (pc_src !== 1'b0 || pc_write !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL drain1 got src=%b pcw=%b halt=%b exp 0 0 0", pc_src, pc_write, halted); end
      n_chk++; if (exc_cause !== 2'b01 || epc !== 64'h10) begin n_fail++; $display("FAIL drain_exc got %b %h exp 01 10", exc_cause, epc); end
      @(negedge clk);
      idle();
      n_chk++; if (halted !== 1'b0 || flush_cnt !== 4'd1) begin n_fail++; $display("FAIL drain2 got halt=%b flush=%0d exp 0 1", halted, flush_cnt); end
      @(negedge clk);
      n_chk++; if (halted !== 1'b1 || exc_cause !== 2'b01 || epc !== 64'h10) begin n_fail++; $display("FAIL inv_op_halt got %b %b %h exp 1 01 10", halted, exc_cause, epc); end
      repeat (4) @(negedge clk);
      n_chk++; if ({halted, pc_write, if_id_write, ex_mem_flush} !== 4'b1001) begin n_fail++; $display("FAIL halt_sticky got %b exp 1001", {halted, pc_write, if_id_write, ex_mem_flush}); end
      apply_reset();
   endtask

   task automatic test_inv_addr_in_drain();
      id_inv_op = 1; id_pc = 64'h20;
      @(negedge clk);
      idle();
      mem_inv_addr = 1; mem_pc = 64'h08;
      #1;
      n_chk++; if (mem_kill !== 1'b1 || pc_write !== 1'b0) begin n_fail++; $display("FAIL drain_inv_addr_kill got kill=%b pcw=%b exp 1 0", mem_kill, pc_write); end
      @(negedge clk);
      idle();
      n_chk++; if (halted !== 1'b1 || exc_cause !== 2'b10 || epc !== 64'h08) begin n_fail++; $display("FAIL drain_inv_addr_halt got %b %b %h exp 1 10 08", halted, exc_cause, epc); end
      n_chk++; if (mem_kill !== 1'b0) begin n_fail++; $display("FAIL halt_kill got %b exp 0", mem_kill); end
      apply_reset();
      mem_inv_addr = 1; mem_pc = 64'h30; mem_branch = 1; mem_zero = 1;
      #1;
      n_chk++; if (mem_kill !== 1'b1 || pc_src !== 1'b0 || pc_write !== 1'b0) begin n_fail++; $display("FAIL run_inv_addr got kill=%b src=%b pcw=%b exp 1 0 0", mem_kill, pc_src, pc_write); end
      @(negedge clk);
      idle();
      n_chk++; if (halted !== 1'b1 || exc_cause !== 2'b10 || epc !== 64'h30 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL run_inv_addr_halt got %b %b %h %0d exp 1 10 30 0", halted, exc_cause, epc, flush_cnt); end
      apply_reset();
   endtask

   task automatic test_reset_mid_drain();
      id_inv_op = 1; id_pc = 64'h44;
      @(negedge clk);
      idle();
      rst_n = 0;
      #1;
      n_chk++; if (halted !== 1'b0 || exc_cause !== 2'b00 || epc !== 64'h0 || cycle_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_drain_reset got %b %b %h %0d exp 0 00 0 0", halted, exc_cause, epc, cycle_cnt); end
      @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      n_chk++; if (halted !== 1'b0 || pc_write !== 1'b1) begin n_fail++; $display("FAIL after_abort got halt=%b pcw=%b exp 0 1", halted, pc_write); end
   endtask

   task automatic test_saturation();
      apply_reset();
      repeat (20) @(negedge clk);
      n_chk++; if (cycle_cnt !== 4'hF) begin n_fail++; $display("FAIL cycle_sat got %h exp F", cycle_cnt); end
      repeat (3) @(negedge clk);
      n_chk++; if (cycle_cnt !== 4'hF) begin n_fail++; $display("FAIL cycle_hold got %h exp F", cycle_cnt); end
   endtask

   initial begin
      test_reset();
      test_load_x0();
      test_load_use();
      test_branch_priority();
      test_inv_op();
      test_inv_addr_in_drain();
      test_reset_mid_drain();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
